// File: rtl/sram_access_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: the core memory port, the JTAG
// debug port and the MCU pause qualifier. Requesters drive it via 'master',
// the arbiter consumes it via 'slave'.
interface sram_access_arbiter_if;
   logic        isPaused;

   logic        coreReq;
   logic        coreWr;
   logic [15:0] coreAddr;
   logic [15:0] coreWData;
   logic [15:0] coreRData;
   logic        coreDone;
   logic        coreStall;

   logic        jtagReq;
   logic        jtagWr;
   logic [15:0] jtagAddr;
   logic [15:0] jtagWData;
   logic [15:0] jtagRData;
   logic        jtagDone;
   logic        jtagErr;

   modport master (
      output isPaused,
      output coreReq, coreWr, coreAddr, coreWData,
      input  coreRData, coreDone, coreStall,
      output jtagReq, jtagWr, jtagAddr, jtagWData,
      input  jtagRData, jtagDone, jtagErr
   );

   modport slave (
      input  isPaused,
      input  coreReq, coreWr, coreAddr, coreWData,
      output coreRData, coreDone, coreStall,
      input  jtagReq, jtagWr, jtagAddr, jtagWData,
      output jtagRData, jtagDone, jtagErr
   );
endinterface

// File: rtl/sram_access_arbiter.sv
// Sole owner of the external SRAM pins. Arbitrates between the core port and
// the JTAG debug port (JTAG first, and only while the MCU is paused), then runs
// each access as a fixed-length chip-enable window, an optional bus turnaround
// after writes, and a one-cycle done pulse back to the winning requester.
module sram_access_arbiter #(
   parameter int ACC_CYCLES  = 2,   // sramEn width per access, 1..15
   parameter int TURN_CYCLES = 1    // idle cycles after a write, 0..3
) (
   input  logic                  clk,
   input  logic                  rstn,
   sram_access_arbiter_if.slave  reqBus,
   output logic [15:0]           sramAddr,
   inout  wire  [15:0]           sramData,
   output logic                  sramWr,
   output logic                  sramEn
);

   typedef enum logic [1:0] {IDLE, ACCESS, TURN, DONE} stateT;

   localparam logic [3:0] ACC_LOAD  = 4'(ACC_CYCLES - 1);
   localparam bit         HAS_TURN  = (TURN_CYCLES > 0);
   localparam logic [3:0] TURN_LOAD = HAS_TURN ? 4'(TURN_CYCLES - 1) : 4'd0;

   stateT       state;
   stateT       stateNext;
   logic [3:0]  cnt;
   logic [3:0]  cntNext;

   logic        grantJtag;
   logic        grantCore;
   logic        refuseJtag;
   logic        captureRead;

   // Request latched at grant; the requester inputs are ignored afterwards.
   logic        ownerJtag;
   logic        refused;
   logic        latWr;
   logic [15:0] latAddr;
   logic [15:0] latWData;

   logic [15:0] coreRDataQ;
   logic [15:0] jtagRDataQ;
   logic        coreDoneInt;

   // Next-state logic: arbitration in IDLE, access/turnaround countdown.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      stateNext   = state;
      cntNext     = cnt;
      grantJtag   = 1'b0;
      grantCore   = 1'b0;
      refuseJtag  = 1'b0;
      captureRead = 1'b0;
      unique case (state)
         IDLE: begin
            if (reqBus.jtagReq && reqBus.isPaused) begin
               grantJtag = 1'b1;
               stateNext = ACCESS;
               cntNext   = ACC_LOAD;
            end else if (reqBus.jtagReq) begin
               // Running MCU: refuse JTAG at once, no SRAM activity.
               refuseJtag = 1'b1;
               stateNext  = DONE;
            end else if (reqBus.coreReq) begin
               grantCore = 1'b1;
               stateNext = ACCESS;
               cntNext   = ACC_LOAD;
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               captureRead = !latWr;
               if (latWr && HAS_TURN) begin
                  stateNext = TURN;
                  cntNext   = TURN_LOAD;
               end else begin
                  stateNext = DONE;
               end
            end else begin
               cntNext = cnt - 4'd1;
            end
         end
         TURN: begin
            if (cnt == 4'd0) stateNext = DONE;
            else             cntNext   = cnt - 4'd1;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State register and countdown; reset aborts any access with no done pulse.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rstn) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Capture owner, direction, address and data of the winning request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ownerJtag <= 1'b0;
         refused   <= 1'b0;
         latWr     <= 1'b0;
         latAddr   <= 16'h0000;
         latWData  <= 16'h0000;
      end else if (grantJtag || grantCore || refuseJtag) begin
         ownerJtag <= !grantCore;
         refused   <= refuseJtag;
         latWr     <= grantJtag ? reqBus.jtagWr : (grantCore && reqBus.coreWr);
         latAddr   <= grantCore ? reqBus.coreAddr  : reqBus.jtagAddr;
         latWData  <= grantCore ? reqBus.coreWData : reqBus.jtagWData;
      end
   end

   // Read data lands in the owner's register on the last ACCESS cycle and holds.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         coreRDataQ <= 16'h0000;
         jtagRDataQ <= 16'h0000;
      end else if (captureRead) begin
         if (ownerJtag) jtagRDataQ <= sramData;
         else           coreRDataQ <= sramData;
      end
   end

   // Pins are only active inside ACCESS; the bus is driven only for writes.
   assign sramEn   = (state == ACCESS);
   assign sramWr   = sramEn && latWr;
   assign sramAddr = sramEn ? latAddr : 16'h0000;
   assign sramData = sramWr ? latWData : 16'hzzzz;

   assign coreDoneInt      = (state == DONE) && !ownerJtag;
   assign reqBus.coreDone  = coreDoneInt;
   assign reqBus.coreStall = reqBus.coreReq && !coreDoneInt;
   assign reqBus.coreRData = coreRDataQ;
   assign reqBus.jtagDone  = (state == DONE) && ownerJtag;
   assign reqBus.jtagErr   = (state == DONE) && ownerJtag && refused;
   assign reqBus.jtagRData = jtagRDataQ;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: three instances with different timing
// parameters, each with a behavioural SRAM on its pins. Expected timing comes
// from the latency rules, expected read data from a reference memory that is
// updated only when a write transaction completes.
module tb_sram_access_arbiter;

   localparam int NDUT = 3;

   function automatic int accOf(input int s);
      case (s)
         1:       return 1;
         2:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int turnOf(input int s);
      case (s)
         1:       return 0;
         2:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int key(input int s, input logic [15:0] a);
      return s * 65536 + int'(a);
   endfunction

   logic        clk = 1'b0;
   logic        rstn;

   logic        isPaused  [NDUT];
   logic        coreReq   [NDUT];
   logic        coreWr    [NDUT];
   logic [15:0] coreAddr  [NDUT];
   logic [15:0] coreWData [NDUT];
   logic [15:0] coreRData [NDUT];
   logic        coreDone  [NDUT];
   logic        coreStall [NDUT];
   logic        jtagReq   [NDUT];
   logic        jtagWr    [NDUT];
   logic [15:0] jtagAddr  [NDUT];
   logic [15:0] jtagWData [NDUT];
   logic [15:0] jtagRData [NDUT];
   logic        jtagDone  [NDUT];
   logic        jtagErr   [NDUT];
   logic [15:0] sramAddr  [NDUT];
   logic [15:0] sramObs   [NDUT];
   logic        sramWr    [NDUT];
   logic        sramEn    [NDUT];

   logic [15:0] refMem [int];
   int          nTests = 0;
   int          nFail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : gDut
      sram_access_arbiter_if bus ();
      wire  [15:0] sramData;
      logic [15:0] mem [0:65535];

      assign bus.isPaused  = isPaused[g];
      assign bus.coreReq   = coreReq[g];
      assign bus.coreWr    = coreWr[g];
      assign bus.coreAddr  = coreAddr[g];
      assign bus.coreWData = coreWData[g];
      assign bus.jtagReq   = jtagReq[g];
      assign bus.jtagWr    = jtagWr[g];
      assign bus.jtagAddr  = jtagAddr[g];
      assign bus.jtagWData = jtagWData[g];
      assign coreRData[g]  = bus.coreRData;
      assign coreDone[g]   = bus.coreDone;
      assign coreStall[g]  = bus.coreStall;
      assign jtagRData[g]  = bus.jtagRData;
      assign jtagDone[g]   = bus.jtagDone;
      assign jtagErr[g]    = bus.jtagErr;

      sram_access_arbiter #(
         .ACC_CYCLES  (accOf(g)),
         .TURN_CYCLES (turnOf(g))
      ) dut (
         .clk      (clk),
         .rstn     (rstn),
         .reqBus   (bus),
         .sramAddr (sramAddr[g]),
         .sramData (sramData),
         .sramWr   (sramWr[g]),
         .sramEn   (sramEn[g])
      );

      // Behavioural SRAM chip: drives the bus during enabled reads only.
      assign sramData   = (sramEn[g] && !sramWr[g]) ? mem[sramAddr[g]] : 16'hzzzz;
      assign sramObs[g] = sramData;

      // Chip stores on every enabled write cycle.
      always @(posedge clk) begin
         if (sramEn[g] && sramWr[g]) mem[sramAddr[g]] <= sramData;
      end
   end

   // One transaction on instance s, checked cycle by cycle against the latency rules.
   task automatic doAccess(input int s, input bit useJtag, input bit paused, input bit wr,
                           input logic [15:0] addr, input logic [15:0] wdata, input bit dropReq);
      int          acc;
      int          expDone;
      bit          refused;
      bit          expEn;
      bit          expDoneNow;
      logic [15:0] expR;
      logic [15:0] prevCore;
      logic [15:0] prevJtag;
      acc     = accOf(s);
      refused = useJtag && !paused;
      expDone = refused ? 1 : acc + ((wr && turnOf(s) > 0) ? turnOf(s) : 0) + 1;
      expR    = 16'h0000;
      if (!refused && !wr) expR = refMem[key(s, addr)];
      @(negedge clk);
      prevCore    = coreRData[s];
      prevJtag    = jtagRData[s];
      isPaused[s] = paused;
      if (useJtag) begin
         jtagReq[s] = 1'b1; jtagWr[s] = wr; jtagAddr[s] = addr; jtagWData[s] = wdata;
      end else begin
         coreReq[s] = 1'b1; coreWr[s] = wr; coreAddr[s] = addr; coreWData[s] = wdata;
      end
      for (int c = 1; c <= expDone; c++) begin
         @(negedge clk);
         expEn      = !refused && (c <= acc);
         expDoneNow = (c == expDone);
         nTests++;
         if (sramEn[s] !== expEn) begin
            nFail++; $display("FAIL sramEn dut%0d cycle %0d: got %b want %b", s, c, sramEn[s], expEn);
         end
         nTests++;
         if (sramWr[s] !== (expEn && wr)) begin
            nFail++; $display("FAIL sramWr dut%0d cycle %0d: got %b want %b", s, c, sramWr[s], expEn && wr);
         end
         nTests++;
         if (coreDone[s] !== (!useJtag && expDoneNow)) begin
            nFail++; $display("FAIL coreDone dut%0d cycle %0d: got %b want %b", s, c, coreDone[s], !useJtag && expDoneNow);
         end
         nTests++;
         if (jtagDone[s] !== (useJtag && expDoneNow)) begin
            nFail++; $display("FAIL jtagDone dut%0d cycle %0d: got %b want %b", s, c, jtagDone[s], useJtag && expDoneNow);
         end
         nTests++;
         if (jtagErr[s] !== (refused && expDoneNow)) begin
            nFail++; $display("FAIL jtagErr dut%0d cycle %0d: got %b want %b", s, c, jtagErr[s], refused && expDoneNow);
         end
         nTests++;
         if (coreStall[s] !== (coreReq[s] && !(!useJtag && expDoneNow))) begin
            nFail++; $display("FAIL coreStall dut%0d cycle %0d: got %b want %b", s, c, coreStall[s],
                              coreReq[s] && !(!useJtag && expDoneNow));
         end
         if (expEn) begin
            nTests++;
            if (sramAddr[s] !== addr) begin
               nFail++; $display("FAIL sramAddr dut%0d cycle %0d: got %h want %h", s, c, sramAddr[s], addr);
            end
            if (wr) begin
               nTests++;
               if (sramObs[s] !== wdata) begin
                  nFail++; $display("FAIL sramData dut%0d cycle %0d: got %h want %h", s, c, sramObs[s], wdata);
               end
            end
         end else begin
            nTests++;
            if (!(sramObs[s] === 16'h0000 || sramObs[s] === 16'hzzzz)) begin
               nFail++; $display("FAIL busIdle dut%0d cycle %0d: got %h want high-Z", s, c, sramObs[s]);
            end
         end
         if (expDoneNow) begin
            nTests++;
            if (useJtag) begin
               if (jtagRData[s] !== ((refused || wr) ? prevJtag : expR)) begin
                  nFail++; $display("FAIL jtagRData dut%0d: got %h want %h", s, jtagRData[s], (refused || wr) ? prevJtag : expR);
               end
            end else begin
               if (coreRData[s] !== (wr ? prevCore : expR)) begin
                  nFail++; $display("FAIL coreRData dut%0d: got %h want %h", s, coreRData[s], wr ? prevCore : expR);
               end
            end
            nTests++;
            if (useJtag ? (coreRData[s] !== prevCore) : (jtagRData[s] !== prevJtag)) begin
               nFail++; $display("FAIL otherRData dut%0d: core %h/%h jtag %h/%h (got/want)", s,
                                 coreRData[s], prevCore, jtagRData[s], prevJtag);
            end
         end
         if (c == 1) begin
            // Post-grant inputs must not matter; pause may also fall mid-access.
            if (useJtag) begin
               jtagWr[s] = 1'($urandom_range(0, 1)); jtagAddr[s] = 16'($urandom); jtagWData[s] = 16'($urandom);
               isPaused[s] = 1'($urandom_range(0, 1));
               if (dropReq) jtagReq[s] = 1'b0;
            end else begin
               coreWr[s] = 1'($urandom_range(0, 1)); coreAddr[s] = 16'($urandom); coreWData[s] = 16'($urandom);
               if (dropReq) coreReq[s] = 1'b0;
            end
         end
      end
      coreReq[s] = 1'b0;
      jtagReq[s] = 1'b0;
      if (!refused && wr) refMem[key(s, addr)] = wdata;
      @(negedge clk);
      nTests++;
      if ({coreDone[s], jtagDone[s], sramEn[s]} !== 3'b000) begin
         nFail++; $display("FAIL afterDone dut%0d: done/done/en got %b%b%b want 000", s, coreDone[s], jtagDone[s], sramEn[s]);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      for (int s = 0; s < NDUT; s++) begin
         nTests++;
         if ({sramEn[s], sramWr[s], coreDone[s], jtagDone[s], jtagErr[s], coreStall[s]} !== 6'b0) begin
            nFail++; $display("FAIL resetCtl dut%0d: got %b%b%b%b%b%b want 000000", s, sramEn[s], sramWr[s],
                              coreDone[s], jtagDone[s], jtagErr[s], coreStall[s]);
         end
         nTests++;
         if (sramAddr[s] !== 16'h0000) begin
            nFail++; $display("FAIL resetAddr dut%0d: got %h want 0000", s, sramAddr[s]);
         end
         nTests++;
         if ({coreRData[s], jtagRData[s]} !== 32'h0) begin
            nFail++; $display("FAIL resetRData dut%0d: got %h %h want 0000 0000", s, coreRData[s], jtagRData[s]);
         end
         nTests++;
         if (!(sramObs[s] === 16'h0000 || sramObs[s] === 16'hzzzz)) begin
            nFail++; $display("FAIL resetBus dut%0d: got %h want high-Z", s, sramObs[s]);
         end
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_core_write_read();
      doAccess(0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
      doAccess(0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
   endtask

   task automatic test_jtag_refused();
      doAccess(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
      doAccess(0, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h7777, 1'b0);
   endtask

   task automatic test_jtag_paused();
      doAccess(0, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'hA5A5, 1'b0);
      doAccess(0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0);
   endtask

   // JTAG and core raised together while paused: JTAG first, core at the next IDLE.
   task automatic test_collision();
      int          acc;
      int          jDone;
      int          cDone;
      logic [15:0] jData;
      logic [15:0] expR;
      acc   = accOf(0);
      jDone = acc + turnOf(0) + 1;
      cDone = jDone + acc + 2;
      jData = 16'($urandom_range(1, 65535));
      expR  = refMem[key(0, 16'h1234)];
      @(negedge clk);
      isPaused[0] = 1'b1;
      jtagReq[0] = 1'b1; jtagWr[0] = 1'b1; jtagAddr[0] = 16'h0040; jtagWData[0] = jData;
      coreReq[0] = 1'b1; coreWr[0] = 1'b0; coreAddr[0] = 16'h1234; coreWData[0] = 16'h0000;
      for (int c = 1; c <= cDone; c++) begin
         @(negedge clk);
         nTests++;
         if (jtagDone[0] !== (c == jDone)) begin
            nFail++; $display("FAIL collJtagDone cycle %0d: got %b want %b", c, jtagDone[0], c == jDone);
         end
         nTests++;
         if (coreDone[0] !== (c == cDone)) begin
            nFail++; $display("FAIL collCoreDone cycle %0d: got %b want %b", c, coreDone[0], c == cDone);
         end
         nTests++;
         if (coreStall[0] !== (c != cDone)) begin
            nFail++; $display("FAIL collStall cycle %0d: got %b want %b", c, coreStall[0], c != cDone);
         end
         nTests++;
         if (sramEn[0] !== ((c <= acc) || (c >= jDone + 2 && c <= jDone + 1 + acc))) begin
            nFail++; $display("FAIL collEn cycle %0d: got %b want %b", c, sramEn[0],
                              (c <= acc) || (c >= jDone + 2 && c <= jDone + 1 + acc));
         end
         if (c == jDone) jtagReq[0] = 1'b0;
         if (c == cDone) begin
            nTests++;
            if (coreRData[0] !== expR) begin
               nFail++; $display("FAIL collRData: got %h want %h", coreRData[0], expR);
            end
         end
      end
      coreReq[0] = 1'b0;
      refMem[key(0, 16'h0040)] = jData;
      doAccess(0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      isPaused[0] = 1'b0;
      coreReq[0] = 1'b1; coreWr[0] = 1'b1; coreAddr[0] = 16'h2000; coreWData[0] = 16'h5A5A;
      @(negedge clk);
      nTests++;
      if (sramWr[0] !== 1'b1) begin
         nFail++; $display("FAIL midPre: sramWr got %b want 1", sramWr[0]);
      end
      #2 rstn = 1'b0;
      #1;
      nTests++;
      if ({sramEn[0], sramWr[0], coreDone[0], jtagDone[0]} !== 4'b0000) begin
         nFail++; $display("FAIL midReset: en/wr/done/done got %b%b%b%b want 0000", sramEn[0], sramWr[0], coreDone[0], jtagDone[0]);
      end
      nTests++;
      if (!(sramObs[0] === 16'h0000 || sramObs[0] === 16'hzzzz)) begin
         nFail++; $display("FAIL midResetBus: got %h want high-Z", sramObs[0]);
      end
      coreReq[0] = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         nTests++;
         if ({coreDone[0], jtagDone[0], sramEn[0]} !== 3'b000) begin
            nFail++; $display("FAIL postReset cycle %0d: got %b%b%b want 000", c, coreDone[0], jtagDone[0], sramEn[0]);
         end
      end
      doAccess(0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
   endtask

   task automatic test_param_sweep();
      for (int s = 1; s < NDUT; s++) begin
         doAccess(s, 1'b0, 1'b0, 1'b1, 16'h0300, 16'hC3C3, 1'b0);
         doAccess(s, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0);
         doAccess(s, 1'b1, 1'b1, 1'b1, 16'h0301, 16'h3C3C, 1'b1);
         doAccess(s, 1'b1, 1'b1, 1'b0, 16'h0301, 16'h0000, 1'b0);
         doAccess(s, 1'b1, 1'b0, 1'b0, 16'h0301, 16'h0000, 1'b0);
      end
   endtask

   task automatic test_random(input int s, input int n);
      bit          useJtag;
      bit          paused;
      bit          wr;
      bit          dropReq;
      logic [15:0] addr;
      logic [15:0] wdata;
      for (int i = 0; i < n; i++) begin
         useJtag = 1'($urandom_range(0, 1));
         paused  = ($urandom_range(0, 3) != 0);
         wr      = 1'($urandom_range(0, 1));
         addr    = 16'h0100 + 16'($urandom_range(0, 15));
         wdata   = 16'($urandom_range(1, 65535));
         dropReq = ($urandom_range(0, 3) == 0);
         if (!wr && !refMem.exists(key(s, addr))) wr = 1'b1;
         doAccess(s, useJtag, paused, wr, addr, wdata, dropReq);
      end
   endtask

   // Test sequence and summary.
   initial begin
      rstn = 1'b0;
      for (int s = 0; s < NDUT; s++) begin
         isPaused[s] = 1'b0;
         coreReq[s] = 1'b0; coreWr[s] = 1'b0; coreAddr[s] = 16'h0; coreWData[s] = 16'h0;
         jtagReq[s] = 1'b0; jtagWr[s] = 1'b0; jtagAddr[s] = 16'h0; jtagWData[s] = 16'h0;
      end
      test_reset();
      test_core_write_read();
      test_jtag_refused();
      test_jtag_paused();
      test_collision();
      test_reset_mid_access();
      test_param_sweep();
      for (int s = 0; s < NDUT; s++) test_random(s, 30);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Single owner of the external SRAM pins. It arbitrates between the core memory port and the JTAG debug port, and sequences every access as a fixed-length multi-cycle chip access. It drives the address, enable, write and bidirectional data pins, and returns read data and a done/stall handshake to the winning requester. It sits between the core, the JTAG command logic and the SRAM chip pins, and uses the core clock domain.

Parameters:
ACC_CYCLES, 2, cycles sramEn is held per access (legal range 1..15)
TURN_CYCLES, 1, idle cycles inserted after a write before any following access (legal range 0..3)

Ports:
clk  input  1  core clock; all logic on its rising edge
rstn  input  1  asynchronous active-low reset
isPaused  input  1  MCU paused; JTAG access is permitted only while this is high
coreReq  input  1  core access request; level, held until coreDone
coreWr  input  1  1=write, 0=read; sampled at grant
coreAddr  input  16  core word address
coreWData  input  16  core write data
coreRData  output  16  core read data; valid during coreDone
coreDone  output  1  one-cycle pulse at end of core access
coreStall  output  1  high while coreReq=1 and the core access has not completed
jtagReq  input  1  JTAG access request; level, held until jtagDone (already synchronised to clk)
jtagWr  input  1  1=write, 0=read
jtagAddr  input  16  JTAG address
jtagWData  input  16  JTAG write data
jtagRData  output  16  JTAG read data; valid during jtagDone
jtagDone  output  1  one-cycle pulse at end of JTAG request
jtagErr  output  1  pulses with jtagDone when the request was refused
sramAddr  output  16  SRAM address pins
sramData  inout  16  SRAM data pins; driven only during write access cycles, otherwise high-Z
sramWr  output  1  SRAM write strobe, active high
sramEn  output  1  SRAM chip enable, active high

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; all outputs 0; sramData high-Z; internal counters and latches 0. Reset mid-access aborts the access immediately, with no done pulse.
- States: IDLE, ACCESS, TURN, DONE.
- IDLE, arbitration in priority order:
  - jtagReq and isPaused: grant JTAG.
  - jtagReq and not isPaused: go to DONE with owner JTAG and jtagErr=1. No SRAM activity.
  - coreReq (JTAG not granted): grant core.
  - Otherwise: stay in IDLE.
- Grant: latch owner, Wr, Addr and WData into registers, then enter ACCESS with counter=ACC_CYCLES-1. Requester inputs are ignored after the grant.
- ACCESS:
  - sramEn=1, sramAddr=latched address, sramWr=latched Wr.
  - sramData is driven with the latched data only if Wr=1.
  - Counter decrements each cycle. On the cycle the counter is 0, a read captures sramData into the owner's RData register.
  - Exit to TURN if Wr=1 and TURN_CYCLES>0, else to DONE.
- TURN: sramEn=0, sramWr=0, bus high-Z for exactly TURN_CYCLES cycles, then DONE.
- DONE: one cycle. Owner's Done=1 and RData holds the captured value; RData holds until the next read by that owner. Always returns to IDLE.
- Back-to-back requests: IDLE lasts at least one cycle between accesses.
- Read latency: grant cycle + ACC_CYCLES + DONE, i.e. coreDone arrives ACC_CYCLES+1 cycles after the first IDLE cycle with coreReq sampled.
- Write latency: ACC_CYCLES+TURN_CYCLES+1 cycles.
- coreStall = coreReq and not coreDone (combinational).
- Simultaneous coreReq and jtagReq with isPaused=1: JTAG wins, the core waits.
- With isPaused=0, JTAG never wins; it is refused immediately.
- isPaused falling mid JTAG access: the access completes normally. Pause is checked only at grant.
- Requester drops Req mid-access: the access still completes and Done still pulses.
- sramWr and sramEn are never 1 outside ACCESS. sramData is never driven outside write-ACCESS cycles.

Test Plan:
- Core write then read, defaults: coreReq wr addr 0x1234 data 0xBEEF, then read 0x1234. Write: sramEn high for 2 cycles, 1 TURN cycle, coreDone at cycle 4. Read: coreRData=0xBEEF with coreDone 3 cycles after request.
- JTAG refused when running: isPaused=0, jtagReq read 0x0010 -> jtagDone+jtagErr on the cycle after request, sramEn stays 0, jtagRData unchanged.
- Paused JTAG write/read: isPaused=1, JTAG write 0x00FF<=0xA5A5, then read -> jtagRData=0xA5A5, jtagErr=0 on both.
- Collision: isPaused=1, coreReq and jtagReq raised on the same cycle -> JTAG access runs first; core granted at the next IDLE; coreStall is high throughout until coreDone.
- Reset mid-access: rstn low during the ACCESS of a write -> sramEn, sramWr and done go to 0 immediately, sramData goes high-Z; after release, state is IDLE and no done pulse occurs.
- Parameter sweep: ACC_CYCLES=1,TURN_CYCLES=0 and ACC_CYCLES=4,TURN_CYCLES=3 -> sramEn width and done timing match the latency formulas; the bus is never driven during TURN.
